// File: rtl/pc_tx_serialiser.sv
// ---------------------------------------------------------------------------
// pc_tx_serialiser
//
// Splits one 32-bit word from the PC_TX FIFO into bytes and hands them to the
// UART transmitter one at a time. Each byte is issued with a one-cycle strobe,
// and the next byte waits for the UART completion pulse plus an optional gap.
//
// Parameters
//   MSB_FIRST      1: bits 31:24 go first, 0: bits 7:0 go first
//   BYTE_GAP_CLKS  idle clocks between a completion pulse and the next strobe
//   TERM_BYTE      delimiter value (exists only with TX_SERIALISER_TERM_EN)
//
// Build option
//   TX_SERIALISER_TERM_EN  append TERM_BYTE as a fifth byte after each word
//
// Ports
//   i_clock       system clock, rising edge
//   i_reset       asynchronous active-high reset
//   i_word_data   word to serialise, sampled on accept
//   i_word_valid  word present; accepted only while o_busy=0
//   o_busy        word in progress
//   o_tx_dv       one-cycle start strobe to the UART
//   o_tx_byte     byte to the UART, held from strobe until completion
//   i_tx_done     one-cycle UART completion pulse
//   o_word_done   one-cycle pulse when the last byte of a word completes
//   o_words_sent  completed word count, wraps at 16 bits
// ---------------------------------------------------------------------------
module pc_tx_serialiser #(
    parameter bit MSB_FIRST     = 1'b1,
    parameter int BYTE_GAP_CLKS = 0
`ifdef TX_SERIALISER_TERM_EN
    ,
    parameter logic [7:0] TERM_BYTE = 8'h0A
`endif
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_word_data,
    input  logic        i_word_valid,
    output logic        o_busy,
    output logic        o_tx_dv,
    output logic [7:0]  o_tx_byte,
    input  logic        i_tx_done,
    output logic        o_word_done,
    output logic [15:0] o_words_sent
);

`ifdef TX_SERIALISER_TERM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif
    localparam logic [15:0] GAP_LOAD = 16'(BYTE_GAP_CLKS);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

    state_t      state_q, state_d;
    logic [31:0] shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] gap_q, gap_d;
    logic [15:0] words_sent_q, words_sent_d;
    logic [7:0]  byte_q, byte_d;
    logic        busy_q, dv_q, word_done_q, word_done_d;

    // Byte at the head of the shift register for the given index. The data
    // bytes are consumed from the head, so only the index of the terminator
    // matters here.
    function automatic logic [7:0] head_byte(input logic [31:0] sr, input logic [2:0] idx);
        logic [7:0] b;
        b = MSB_FIRST ? sr[31:24] : sr[7:0];
`ifdef TX_SERIALISER_TERM_EN
        if (idx == LAST_IDX) b = TERM_BYTE;
`else
        if (idx > LAST_IDX) b = 8'h00;
`endif
        return b;
    endfunction

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        words_sent_d = words_sent_q;
        word_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // A done pulse here is stale (e.g. after reset) and ignored.
                if (i_word_valid) begin
                    shift_d = i_word_data;
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: state_d = WAIT;
            WAIT: begin
                if (i_tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        word_done_d  = 1'b1;
                        words_sent_d = words_sent_q + 16'd1;
                        state_d      = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = MSB_FIRST ? {shift_q[23:0], 8'h00} : {8'h00, shift_q[31:8]};
                        if (GAP_LOAD == 16'd0) begin
                            state_d = SEND;
                        end else begin
                            gap_d   = GAP_LOAD;
                            state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                // Loaded with N, leaves after N cycles in this state.
                gap_d = gap_q - 16'd1;
                if (gap_q == 16'd1) state_d = SEND;
            end
            default: state_d = IDLE;
        endcase

        // The byte register only loads when a strobe is about to go out, so it
        // stays frozen while the UART is shifting.
        byte_d = (state_d == SEND) ? head_byte(shift_d, idx_d) : byte_q;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            shift_q      <= 32'h0;
            idx_q        <= 3'd0;
            gap_q        <= 16'h0;
            words_sent_q <= 16'h0;
            byte_q       <= 8'h00;
            busy_q       <= 1'b0;
            dv_q         <= 1'b0;
            word_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            words_sent_q <= words_sent_d;
            byte_q       <= byte_d;
            busy_q       <= (state_d != IDLE);
            dv_q         <= (state_d == SEND);
            word_done_q  <= word_done_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_tx_dv      = dv_q;
    assign o_tx_byte    = byte_q;
    assign o_word_done  = word_done_q;
    assign o_words_sent = words_sent_q;

endmodule

// File: tb/tb_pc_tx_serialiser.sv
// Bench for pc_tx_serialiser. Two instances: dut0 (MSB first, no gap) and
// dut1 (LSB first, 3-clock gap). A UART stand-in answers each strobe with a
// done pulse 10 cycles later. A word-level model predicts every output each
// cycle; literal byte sequences pin the model.
module tb_pc_tx_serialiser;
`ifdef TX_SERIALISER_TERM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst, valid, man_done, preset_req;
    logic [1:0]        auto_done = 2'b00;
    logic [1:0]        tx_done, busy, tx_dv, word_done;
    logic [1:0][31:0]  wdata;
    logic [1:0][7:0]   tx_byte;
    logic [1:0][15:0]  words_sent;
    assign tx_done = auto_done | man_done;

    pc_tx_serialiser #(.MSB_FIRST(1'b1), .BYTE_GAP_CLKS(0)) dut0 (
        .i_clock(clk), .i_reset(rst[0]), .i_word_data(wdata[0]), .i_word_valid(valid[0]),
        .o_busy(busy[0]), .o_tx_dv(tx_dv[0]), .o_tx_byte(tx_byte[0]), .i_tx_done(tx_done[0]),
        .o_word_done(word_done[0]), .o_words_sent(words_sent[0]));

    pc_tx_serialiser #(.MSB_FIRST(1'b0), .BYTE_GAP_CLKS(3)) dut1 (
        .i_clock(clk), .i_reset(rst[1]), .i_word_data(wdata[1]), .i_word_valid(valid[1]),
        .o_busy(busy[1]), .o_tx_dv(tx_dv[1]), .o_tx_byte(tx_byte[1]), .i_tx_done(tx_done[1]),
        .o_word_done(word_done[1]), .o_words_sent(words_sent[1]));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, k, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input bit msbf, input logic [31:0] w, input int j);
        if (j >= 4) return 8'h0A;
        return msbf ? 8'((w >> (8 * (3 - j))) & 32'hFF) : 8'((w >> (8 * j)) & 32'hFF);
    endfunction

    // UART stand-in: done pulse 10 cycles after each strobe.
    int rc[2] = '{0, 0};
    always begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            auto_done[k] = 1'b0;
            if (rc[k] > 0) begin
                rc[k]--;
                if (rc[k] == 0) auto_done[k] = 1'b1;
            end
            if (tx_dv[k]) rc[k] = 10;
        end
    end

    // Word-level model and per-cycle compare.
    logic       m_busy[2], m_wd[2], m_wait[2];
    int         m_dv_at[2], m_idx[2], last_done[2];
    logic [7:0] m_byte[2];
    logic [15:0] m_cnt[2];
    logic [7:0] m_bytes[2][5];
    logic [7:0] log_b[2][64];
    int         log_n[2] = '{0, 0};
    int         wd_n[2]  = '{0, 0};
    int         diff[16];
    int         diff_n = 0;
    logic       e_dv;

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                m_busy[k] = 1'b0; m_wd[k] = 1'b0; m_wait[k] = 1'b0; m_dv_at[k] = -1;
                m_idx[k] = 0; m_byte[k] = 8'h00; m_cnt[k] = 16'h0; last_done[k] = -1;
                chk("rst_busy", k, 32'(busy[k]), 32'h0);
                chk("rst_tx_dv", k, 32'(tx_dv[k]), 32'h0);
                chk("rst_tx_byte", k, 32'(tx_byte[k]), 32'h0);
                chk("rst_word_done", k, 32'(word_done[k]), 32'h0);
                chk("rst_words_sent", k, 32'(words_sent[k]), 32'h0);
            end else begin
                if (preset_req[k]) m_cnt[k] = 16'hFFFF;
                e_dv = (m_dv_at[k] == cyc);
                if (e_dv) m_byte[k] = m_bytes[k][m_idx[k]];
                chk("busy", k, 32'(busy[k]), 32'(m_busy[k]));
                chk("tx_dv", k, 32'(tx_dv[k]), 32'(e_dv));
                chk("word_done", k, 32'(word_done[k]), 32'(m_wd[k]));
                chk("words_sent", k, 32'(words_sent[k]), 32'(m_cnt[k]));
                if (m_busy[k]) chk("tx_byte", k, 32'(tx_byte[k]), 32'(m_byte[k]));
                if (tx_dv[k] && log_n[k] < 64) begin
                    log_b[k][log_n[k]] = tx_byte[k];
                    log_n[k]++;
                    if (k == 1 && last_done[1] >= 0 && diff_n < 16) begin
                        diff[diff_n] = cyc - last_done[1];
                        diff_n++;
                    end
                end
                if (word_done[k]) wd_n[k]++;
                // advance to next cycle
                m_wd[k] = 1'b0;
                if (!m_busy[k]) begin
                    if (valid[k]) begin
                        for (int j = 0; j < 5; j++) m_bytes[k][j] = byte_of(k == 0, wdata[k], j);
                        m_idx[k] = 0; m_busy[k] = 1'b1; m_dv_at[k] = cyc + 1; last_done[k] = -1;
                    end
                end else if (m_wait[k] && tx_done[k]) begin
                    m_wait[k] = 1'b0;
                    last_done[k] = cyc;
                    if (m_idx[k] == NB - 1) begin
                        m_busy[k] = 1'b0; m_wd[k] = 1'b1; m_cnt[k] = m_cnt[k] + 16'd1;
                    end else begin
                        m_idx[k]++;
                        m_dv_at[k] = cyc + 1 + ((k == 0) ? 0 : 3);
                    end
                end
                if (e_dv) m_wait[k] = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [31:0] w);
        int b = 0;
        while (busy[k] && b < 400) begin step(); b++; end
        chk("send_ready", k, 32'(busy[k]), 32'h0);
        valid[k] = 1'b1;
        wdata[k] = w;
        step();
        valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int b = 0;
        while (busy[k] && b < 400) begin step(); b++; end
        chk("idle", k, 32'(busy[k]), 32'h0);
    endtask

    task automatic check_word(input string name, input int k, input int pos,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        chk({name, "_b0"}, k, 32'(log_b[k][pos]), 32'(b0));
        chk({name, "_b1"}, k, 32'(log_b[k][pos + 1]), 32'(b1));
        chk({name, "_b2"}, k, 32'(log_b[k][pos + 2]), 32'(b2));
        chk({name, "_b3"}, k, 32'(log_b[k][pos + 3]), 32'(b3));
`ifdef TX_SERIALISER_TERM_EN
        chk({name, "_term"}, k, 32'(log_b[k][pos + 4]), 32'h0A);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, w0, b;
        rst = 2'b11; valid = 2'b00; man_done = 2'b00; preset_req = 2'b00;
        wdata[0] = 32'h0; wdata[1] = 32'h0;
        repeat (3) step();
        rst = 2'b00;
        step();

        // 1: MSB-first ordering
        s = log_n[0]; w0 = wd_n[0];
        send(0, 32'h54455354);
        wait_idle(0);
        step();
        chk("t1_strobes", 0, 32'(log_n[0] - s), 32'(NB));
        check_word("t1", 0, s, 8'h54, 8'h45, 8'h53, 8'h54);
        chk("t1_word_done", 0, 32'(wd_n[0] - w0), 32'd1);
        chk("t1_words_sent", 0, 32'(words_sent[0]), 32'd1);

        // 2: LSB-first with a 3-clock gap
        s = log_n[1];
        send(1, 32'h11223344);
        wait_idle(1);
        step();
        check_word("t2", 1, s, 8'h44, 8'h33, 8'h22, 8'h11);
        chk("t2_gaps", 1, 32'(diff_n), 32'(NB - 1));
        for (int i = 0; i < diff_n; i++) chk("t2_gap_len", 1, 32'(diff[i]), 32'd4);

        // 3: second word held while busy
        s = log_n[0];
        valid[0] = 1'b1; wdata[0] = 32'hAABBCCDD;
        step();
        wdata[0] = 32'h01020304;
        b = 0;
        while (busy[0] && b < 400) begin step(); b++; end
        chk("t3_first_word_only", 0, 32'(log_n[0] - s), 32'(NB));
        step();
        valid[0] = 1'b0;
        wait_idle(0);
        step();
        check_word("t3a", 0, s, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        check_word("t3b", 0, s + NB, 8'h01, 8'h02, 8'h03, 8'h04);
        chk("t3_words_sent", 0, 32'(words_sent[0]), 32'd3);

        // 4: stray done in IDLE and in the strobe cycle
        man_done[0] = 1'b1;
        step();
        man_done[0] = 1'b0;
        step();
        chk("t4_idle_busy", 0, 32'(busy[0]), 32'h0);
        chk("t4_idle_count", 0, 32'(words_sent[0]), 32'd3);
        s = log_n[0];
        send(0, 32'h0BADF00D);
        man_done[0] = 1'b1;
        step();
        man_done[0] = 1'b0;
        wait_idle(0);
        step();
        chk("t4_strobes", 0, 32'(log_n[0] - s), 32'(NB));
        check_word("t4", 0, s, 8'h0B, 8'hAD, 8'hF0, 8'h0D);
        chk("t4_words_sent", 0, 32'(words_sent[0]), 32'd4);

        // 5: reset after the second strobe, late done afterwards
        s = log_n[0];
        send(0, 32'hCAFEBABE);
        b = 0;
        while (log_n[0] - s < 2 && b < 100) begin step(); b++; end
        rst[0] = 1'b1;
        #1;
        chk("t5_busy", 0, 32'(busy[0]), 32'h0);
        chk("t5_tx_dv", 0, 32'(tx_dv[0]), 32'h0);
        chk("t5_tx_byte", 0, 32'(tx_byte[0]), 32'h0);
        chk("t5_word_done", 0, 32'(word_done[0]), 32'h0);
        chk("t5_words_sent", 0, 32'(words_sent[0]), 32'h0);
        step();
        rst[0] = 1'b0;
        man_done[0] = 1'b1;
        step();
        man_done[0] = 1'b0;
        repeat (15) step();
        chk("t5_late_done_busy", 0, 32'(busy[0]), 32'h0);
        chk("t5_late_done_count", 0, 32'(words_sent[0]), 32'h0);
        chk("t5_no_strobes", 0, 32'(log_n[0] - s), 32'd2);
        s = log_n[0];
        send(0, 32'h12345678);
        wait_idle(0);
        step();
        check_word("t5", 0, s, 8'h12, 8'h34, 8'h56, 8'h78);
        chk("t5_words_sent_after", 0, 32'(words_sent[0]), 32'd1);

        // 6: count wrap from 0xFFFF
        force dut0.words_sent_q = 16'hFFFF;
        preset_req[0] = 1'b1;
        #1;
        release dut0.words_sent_q;
        step();
        preset_req[0] = 1'b0;
        chk("t6_preset", 0, 32'(words_sent[0]), 32'hFFFF);
        s = log_n[0];
        send(0, 32'hDEADBEEF);
        wait_idle(0);
        step();
        chk("t6_strobes", 0, 32'(log_n[0] - s), 32'(NB));
        check_word("t6", 0, s, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
        chk("t6_wrap", 0, 32'(words_sent[0]), 32'h0);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
